// File: rtl/hs32_mem_arbiter.sv
// rtl/hs32_mem_arbiter.sv - round-robin two-port memory arbiter for the HS32 core
// One transaction in flight at a time; a saturating counter aborts a bus that never acks.
module hs32_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_addr,
  input  logic        i_reqm,
  output logic [31:0] i_dtr,
  output logic        i_ackm,
  output logic        i_err,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_dtw,
  input  logic        d_rw,
  input  logic        d_reqm,
  output logic [31:0] d_dtr,
  output logic        d_ackm,
  output logic        d_err,
  output logic [31:0] addr,
  output logic [31:0] dtw,
  output logic        rw,
  output logic        reqm,
  input  logic [31:0] dtr,
  input  logic        ackm
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        win_q, win_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] dtw_q, dtw_d;
  logic        rw_q, rw_d;
  logic        reqm_q, reqm_d;
  logic [31:0] i_dtr_q, i_dtr_d;
  logic [31:0] d_dtr_q, d_dtr_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        i_err_q, i_err_d;
  logic        d_err_q, d_err_d;

  logic          grant;
  logic          grant_port;
  logic [TW-1:0] cnt_inc;
  logic          expire;

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant      = i_reqm | d_reqm;
    grant_port = (i_reqm && d_reqm) ? ~last_q : d_reqm;
    cnt_inc    = (cnt_q == {TW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    expire     = (TIMEOUT != 0) && (cnt_inc == TO_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      dtw_q   <= '0;
      rw_q    <= 1'b0;
      reqm_q  <= 1'b0;
      i_dtr_q <= '0;
      d_dtr_q <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dtw_q   <= dtw_d;
      rw_q    <= rw_d;
      reqm_q  <= reqm_d;
      i_dtr_q <= i_dtr_d;
      d_dtr_q <= d_dtr_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      i_err_q <= i_err_d;
      d_err_q <= d_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = BUSY;
      BUSY:    if (ackm || expire) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d  = last_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dtw_d   = dtw_q;
    rw_d    = rw_q;
    reqm_d  = reqm_q;
    i_dtr_d = i_dtr_q;
    d_dtr_d = d_dtr_q;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    i_err_d = 1'b0;
    d_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          win_d  = grant_port;
          last_d = grant_port;
          cnt_d  = '0;
          reqm_d = 1'b1;
          addr_d = grant_port ? d_addr : i_addr;
          dtw_d  = grant_port ? d_dtw : 32'h0;
          rw_d   = grant_port & d_rw;
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        // A real ack in the expiry cycle takes priority over the abort.
        if (ackm) begin
          reqm_d = 1'b0;
          if (win_q) begin
            d_dtr_d = dtr;
            d_ack_d = 1'b1;
          end else begin
            i_dtr_d = dtr;
            i_ack_d = 1'b1;
          end
        end else if (expire) begin
          reqm_d = 1'b0;
          if (win_q) begin
            d_dtr_d = 32'h0;
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end else begin
            i_dtr_d = 32'h0;
            i_ack_d = 1'b1;
            i_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign addr   = addr_q;
  assign dtw    = dtw_q;
  assign rw     = rw_q;
  assign reqm   = reqm_q;
  assign i_dtr  = i_dtr_q;
  assign d_dtr  = d_dtr_q;
  assign i_ackm = i_ack_q;
  assign d_ackm = d_ack_q;
  assign i_err  = i_err_q;
  assign d_err  = d_err_q;

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// tb/tb_hs32_mem_arbiter.sv - self-checking bench for hs32_mem_arbiter
module tb_hs32_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_addr, d_addr, d_dtw, addr, dtw, dtr, i_dtr, d_dtr;
  logic        i_reqm, d_reqm, d_rw, i_ackm, i_err, d_ackm, d_err, rw, reqm, ackm;

  always #5 clk = ~clk;

  hs32_mem_arbiter #(.TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .reset(reset),
    .i_addr(i_addr), .i_reqm(i_reqm), .i_dtr(i_dtr), .i_ackm(i_ackm), .i_err(i_err),
    .d_addr(d_addr), .d_dtw(d_dtw), .d_rw(d_rw), .d_reqm(d_reqm),
    .d_dtr(d_dtr), .d_ackm(d_ackm), .d_err(d_err),
    .addr(addr), .dtw(dtw), .rw(rw), .reqm(reqm), .dtr(dtr), .ackm(ackm)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        port;
    logic [31:0] dtr;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] exp_i_dtr = 32'h0;
  logic [31:0] exp_d_dtr = 32'h0;
  logic        prev_ack  = 1'b0;

  // Memory model: acks in BUSY cycle mem_delay (0 = never), returning mem_key ^ addr.
  logic        mem_en    = 1'b0;
  int          mem_delay = 0;
  logic [31:0] mem_key   = 32'h0;
  logic        man_ack   = 1'b0;
  int          bcnt      = 0;

  initial begin
    ackm = 1'b0;
    dtr  = 32'h0;
  end

  always @(negedge clk) begin
    if (reqm) bcnt = bcnt + 1;
    else bcnt = 0;
    if (mem_en && reqm && mem_delay != 0 && bcnt == mem_delay) begin
      ackm = 1'b1;
      dtr  = mem_key ^ addr;
    end else begin
      ackm = man_ack;
      dtr  = man_ack ? 32'hFFFF_FFFF : 32'h0;
    end
  end

  always @(negedge clk) begin
    if (i_ackm && d_ackm) check("both_acks", 32'(d_ackm), 32'h0);
    if (!i_ackm) check("i_err_outside_resp", 32'(i_err), 32'h0);
    if (!d_ackm) check("d_err_outside_resp", 32'(d_err), 32'h0);
    if (i_ackm || d_ackm) begin
      check("ack_single_pulse", 32'(prev_ack), 32'h0);
      check("reqm_low_in_resp", 32'(reqm), 32'h0);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got i_ackm=%b d_ackm=%b expected none", i_ackm, d_ackm);
      end else begin
        mon_e = sbq.pop_front();
        check("ack_port", 32'(d_ackm), 32'(mon_e.port));
        check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.port) begin
          check("d_dtr", d_dtr, mon_e.dtr);
          check("d_err", 32'(d_err), 32'(mon_e.err));
          check("i_dtr_hold", i_dtr, exp_i_dtr);
          exp_d_dtr = mon_e.dtr;
        end else begin
          check("i_dtr", i_dtr, mon_e.dtr);
          check("i_err", 32'(i_err), 32'(mon_e.err));
          check("d_dtr_hold", d_dtr, exp_d_dtr);
          exp_i_dtr = mon_e.dtr;
        end
      end
    end
    prev_ack = i_ackm | d_ackm;
  end

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] dtw;
    logic        rw;
    int          delay;
    logic [31:0] exp_dtr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    exp_t        e;
    logic        seen;
    logic        exp_rw;
    logic [31:0] exp_dtw;
    int          eff;
    exp_rw    = v.port ? v.rw : 1'b0;
    exp_dtw   = v.port ? v.dtw : 32'h0;
    eff       = (v.delay == 0) ? TO : v.delay;
    mem_en    = 1'b1;
    mem_delay = v.delay;
    mem_key   = v.exp_dtr ^ v.addr;
    e.port = v.port;
    e.dtr  = v.exp_dtr;
    e.err  = v.exp_err;
    e.cyc  = cyc + 1 + eff;
    sbq.push_back(e);
    if (v.port) begin
      d_addr = v.addr;
      d_dtw  = v.dtw;
      d_rw   = v.rw;
      d_reqm = 1'b1;
    end else begin
      i_addr = v.addr;
      i_reqm = 1'b1;
    end
    @(negedge clk);
    check("reqm_latency", 32'(reqm), 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (i_ackm || d_ackm) begin
        seen = 1'b1;
        break;
      end
      check("busy_reqm", 32'(reqm), 32'h1);
      check("busy_addr", addr, v.addr);
      check("busy_rw", 32'(rw), 32'(exp_rw));
      check("busy_dtw", dtw, exp_dtw);
      @(negedge clk);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ack_wait: got no ack within 20 cycles, expected one");
    end
    i_reqm = 1'b0;
    d_reqm = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   c0;
    int   acks;
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h5555_AAAA, 1'b0, 3, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0200, 32'h1234_5678, 1'b1, 2, 32'h1111_2222, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0300, 32'h0,         1'b0, 1, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0400, 32'h0,         1'b0, 0, 32'h0,         1'b1};
    vecs[4] = '{1'b1, 32'h0000_0404, 32'h0,         1'b0, 1, 32'h600D_0001, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0104, 32'h0,         1'b0, TO, 32'hC011_1DE0, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0108, 32'h0,         1'b0, 0, 32'h0,         1'b1};
    vecs[7] = '{1'b0, 32'h0000_010C, 32'h0,         1'b0, 1, 32'h0BAD_F00D, 1'b0};

    reset  = 1'b1;
    i_addr = 32'h0;
    i_reqm = 1'b0;
    d_addr = 32'h0;
    d_dtw  = 32'h0;
    d_rw   = 1'b0;
    d_reqm = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_reqm", 32'(reqm), 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_dtw", dtw, 32'h0);
    check("rst_rw", 32'(rw), 32'h0);
    check("rst_acks", {30'h0, i_ackm, d_ackm}, 32'h0);
    check("rst_dtrs", i_dtr | d_dtr, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 8; n++) run_vec(vecs[n]);

    // Reset in the middle of a transaction, then a stray ack.
    mem_en = 1'b0;
    d_addr = 32'h0000_0500;
    d_dtw  = 32'hAAAA_5555;
    d_rw   = 1'b1;
    d_reqm = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 32'(reqm), 32'h1);
    @(negedge clk);
    reset  = 1'b1;
    d_reqm = 1'b0;
    @(negedge clk);
    exp_i_dtr = 32'h0;
    exp_d_dtr = 32'h0;
    check("rstmid_reqm", 32'(reqm), 32'h0);
    check("rstmid_addr", addr, 32'h0);
    check("rstmid_dtw", dtw, 32'h0);
    check("rstmid_rw", 32'(rw), 32'h0);
    check("rstmid_dtrs", i_dtr | d_dtr, 32'h0);
    reset   = 1'b0;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("late_ack_reqm", 32'(reqm), 32'h0);
      check("late_ack_acks", {30'h0, i_ackm, d_ackm}, 32'h0);
      check("late_ack_dtrs", i_dtr | d_dtr, 32'h0);
    end

    // Both ports held high: first tie after reset goes to fetch, then alternates.
    mem_en    = 1'b1;
    mem_delay = 1;
    mem_key   = 32'h0;
    i_addr    = 32'h0000_0010;
    d_addr    = 32'h0000_0020;
    d_rw      = 1'b0;
    c0        = cyc;
    for (int n = 0; n < 4; n++) begin
      e.port = n[0];
      e.dtr  = n[0] ? 32'h0000_0020 : 32'h0000_0010;
      e.err  = 1'b0;
      e.cyc  = c0 + 2 + 3 * n;
      sbq.push_back(e);
    end
    i_reqm = 1'b1;
    d_reqm = 1'b1;
    acks   = 0;
    for (int k = 0; k < 40 && acks < 4; k++) begin
      @(negedge clk);
      if (i_ackm || d_ackm) acks++;
    end
    check("tie_ack_count", 32'(acks), 32'h4);
    i_reqm = 1'b0;
    d_reqm = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
